// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, addresses instruction memory and registers {pc, instr} for decode.
// Latency: 1 cycle from IMaddress to if_valid/if_instr; 1 instr/cycle sustained.
// Backpressure: stall holds pc and outputs; redirect/halt override stall. Option macro: FETCH_ALIGN_CHECK_EN.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] IMaddress,
    input  logic [31:0] IMinstruction,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instr,
    output logic [31:0] fetch_count,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [31:0] IMEM_LIMIT = IMEM_WORDS;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic ALIGN_CHECK = 1'b1;
`else
    localparam logic ALIGN_CHECK = 1'b0;
`endif

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        in_range;
    logic        misaligned;

    assign IMaddress  = pc;
    // pc+4 wraps naturally; a wrapped pc still meets the range check before it is used.
    assign pc_plus4   = pc + 32'd4;
    assign in_range   = ({2'b00, pc[31:2]} < IMEM_LIMIT);
    assign misaligned = ALIGN_CHECK && (redirect_pc[1:0] != 2'b00);
    assign halted     = (state == S_HALT);

    // Fetch state machine: priority halt > redirect > stall > range check > advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_BOOT;
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_pc       <= 32'd0;
            if_pc_plus4 <= 32'd0;
            if_instr    <= 32'd0;
            fetch_count <= 32'd0;
            fault       <= 1'b0;
            fault_pc    <= 32'd0;
        end else begin
            case (state)
                S_BOOT: begin
                    // One bubble cycle before the first capture.
                    state    <= S_RUN;
                    if_valid <= 1'b0;
                end
                S_RUN: begin
                    if (halt_req) begin
                        state    <= S_HALT;
                        if_valid <= 1'b0;
                    end else if (redirect_valid) begin
                        if_valid <= 1'b0;
                        if (misaligned) begin
                            state    <= S_FAULT;
                            fault    <= 1'b1;
                            fault_pc <= redirect_pc;
                        end else begin
                            pc <= {redirect_pc[31:2], 2'b00};
                        end
                    end else if (stall) begin
                        // Hold pc, delivered instruction and count.
                        state <= S_RUN;
                    end else if (!in_range) begin
                        state    <= S_FAULT;
                        fault    <= 1'b1;
                        fault_pc <= pc;
                        if_valid <= 1'b0;
                    end else begin
                        if_instr    <= IMinstruction;
                        if_pc       <= pc;
                        if_pc_plus4 <= pc_plus4;
                        if_valid    <= 1'b1;
                        pc          <= pc_plus4;
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
                S_HALT: begin
                    if_valid <= 1'b0;
                end
                S_FAULT: begin
                    if_valid <= 1'b0;
                end
                default: begin
                    state    <= S_BOOT;
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: driver pushes expected deliveries, monitor pops on each new if_valid.
// Instruction memory is a combinational pattern of the word address.
// Directed scenarios: boot, stall, redirect+stall, halt, mid-stream reset, misaligned redirect, range fault.
module tb_fetch_sequencer;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IMaddress;
    logic [31:0] IMinstruction;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
    logic [31:0] fetch_count;
    logic        halted;
    logic        fault;
    logic [31:0] fault_pc;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    logic [31:0] exp_cnt = 32'd0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
    endfunction

    assign IMinstruction = imem(IMaddress);

    fetch_sequencer #(.RESET_PC(32'h0), .IMEM_WORDS(1024)) dut (
        .clk(clk), .reset(reset),
        .IMaddress(IMaddress), .IMinstruction(IMinstruction),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req),
        .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_instr(if_instr),
        .fetch_count(fetch_count), .halted(halted), .fault(fault), .fault_pc(fault_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        exp_cnt = exp_cnt + 32'd1;
        e.pc  = pc;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: a new delivery is if_valid after an edge where stall was low; a stalled edge must hold.
    initial begin : monitor
        logic        stall_e;
        logic [31:0] last_pc;
        exp_t        e;
        last_pc = 32'd0;
        forever begin
            @(posedge clk);
            stall_e = stall;
            @(negedge clk);
            if (if_valid === 1'b1 && !stall_e) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_delivery_pc", if_pc, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("if_pc", if_pc, e.pc);
                    chk("if_instr", if_instr, imem(e.pc));
                    chk("if_pc_plus4", if_pc_plus4, e.pc + 32'd4);
                    chk("fetch_count", fetch_count, e.cnt);
                end
                last_pc = if_pc;
            end else if (if_valid === 1'b1 && stall_e) begin
                chk("stall_hold_pc", if_pc, last_pc);
                chk("stall_hold_instr", if_instr, imem(last_pc));
            end
        end
    end

    initial begin : driver
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; halt_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_fetch_count", fetch_count, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_IMaddress", IMaddress, 32'd0);
        reset = 1'b0;
        tick();
        chk("boot_bubble_valid", {31'd0, if_valid}, 32'd0);
        chk("boot_IMaddress", IMaddress, 32'd0);

        // Sequential fetch 0,4,8
        push(32'h0); push(32'h4); push(32'h8);
        repeat (3) tick();

        // Stall three cycles at if_pc=8
        stall = 1'b1;
        repeat (3) tick();
        chk("stall_IMaddress", IMaddress, 32'hC);
        chk("stall_fetch_count", fetch_count, 32'd3);
        chk("stall_if_pc", if_pc, 32'h8);
        stall = 1'b0;
        push(32'hC);
        tick();

        // Redirect together with stall
        redirect_valid = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
        tick();
        chk("redir_bubble_valid", {31'd0, if_valid}, 32'd0);
        chk("redir_IMaddress", IMaddress, 32'h40);
        chk("redir_fetch_count", fetch_count, 32'd4);
        redirect_valid = 1'b0; stall = 1'b0;
        push(32'h40);
        tick();

        // Halt beats simultaneous redirect
        halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_if_valid", {31'd0, if_valid}, 32'd0);
        chk("halt_IMaddress", IMaddress, 32'h44);
        halt_req = 1'b0; redirect_valid = 1'b0;
        repeat (2) tick();
        chk("halt_sticky", {31'd0, halted}, 32'd1);
        chk("halt_pc_hold", IMaddress, 32'h44);
        chk("halt_fetch_count", fetch_count, 32'd5);

        // Reset mid-stream
        reset = 1'b1;
        tick();
        chk("mid_rst_halted", {31'd0, halted}, 32'd0);
        chk("mid_rst_IMaddress", IMaddress, 32'd0);
        chk("mid_rst_count", fetch_count, 32'd0);
        reset = 1'b0; exp_cnt = 32'd0;
        tick();

        // Misaligned redirect target
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("align_fault", {31'd0, fault}, 32'd1);
        chk("align_fault_pc", fault_pc, 32'h42);
        chk("align_if_valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("align_pc_not_updated", IMaddress, 32'h0);
        chk("align_valid_after", {31'd0, if_valid}, 32'd0);
`else
        chk("noalign_fault", {31'd0, fault}, 32'd0);
        chk("noalign_IMaddress", IMaddress, 32'h40);
        chk("noalign_bubble", {31'd0, if_valid}, 32'd0);
        push(32'h40);
        tick();
        chk("noalign_fault_after", {31'd0, fault}, 32'd0);
`endif

        // Full sequential run into the range fault
        reset = 1'b1;
        tick();
        reset = 1'b0; exp_cnt = 32'd0;
        tick();
        for (int i = 0; i < 1024; i++) push(32'(i * 4));
        repeat (1024) tick();
        chk("range_before_fault", {31'd0, fault}, 32'd0);
        chk("range_last_pc", if_pc, 32'hFFC);
        tick();
        chk("range_fault", {31'd0, fault}, 32'd1);
        chk("range_fault_pc", fault_pc, 32'h1000);
        chk("range_if_valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("range_valid_after", {31'd0, if_valid}, 32'd0);
        chk("range_count", fetch_count, 32'd1024);

        // Reset clears fault and restarts at RESET_PC
        reset = 1'b1;
        tick();
        chk("clr_fault", {31'd0, fault}, 32'd0);
        chk("clr_fault_pc", fault_pc, 32'd0);
        chk("clr_IMaddress", IMaddress, 32'd0);
        reset = 1'b0; exp_cnt = 32'd0;
        tick();
        push(32'h0);
        tick();
        stall = 1'b1;
        repeat (2) tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
